// File: rtl/ex_issue_stage_pkg.sv
// Shared CPU definitions for the ID/EX issue stage and the ALU.
//   alu_ctrl_e : ALU operation encoding, shared with the ALU.
//   fwd_sel_e  : operand source chosen by the forwarding selector.
package cpu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    SLT = 3'd5
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_MEM,
    FWD_WB
  } fwd_sel_e;

endpackage

// File: rtl/ex_issue_stage_if.sv
// Bus bundle around the ID/EX issue stage: decode-side handshake and
// instruction fields, flush, MEM/WB producer taps and the EX-side handshake.
//   master : decode/producer/downstream side (drives id_*, flush, mem_*, wb_*, ex_ready)
//   slave  : the issue stage itself
interface ex_issue_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int CTRL_WIDTH     = 3,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      id_valid;
  logic                      id_ready;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic [DATA_WIDTH-1:0]     id_rs1_data;
  logic [DATA_WIDTH-1:0]     id_rs2_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic                      id_use_imm;
  logic [CTRL_WIDTH-1:0]     id_alu_ctrl;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic                      id_reg_write;
  logic                      id_is_load;
  logic                      flush;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic                      mem_reg_write;
  logic                      wb_reg_write;
  logic                      mem_is_load;
  logic [DATA_WIDTH-1:0]     mem_result;
  logic [DATA_WIDTH-1:0]     wb_result;
  logic                      ex_valid;
  logic                      ex_ready;
  logic [DATA_WIDTH-1:0]     ex_op1;
  logic [DATA_WIDTH-1:0]     ex_op2;
  logic [CTRL_WIDTH-1:0]     ex_alu_ctrl;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_reg_write;
  logic                      ex_is_load;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm, id_use_imm,
           id_alu_ctrl, id_rd, id_reg_write, id_is_load, flush,
           mem_rd, wb_rd, mem_reg_write, wb_reg_write, mem_is_load, mem_result, wb_result,
           ex_ready,
    input  id_ready, ex_valid, ex_op1, ex_op2, ex_alu_ctrl, ex_store_data,
           ex_rd, ex_reg_write, ex_is_load
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm, id_use_imm,
           id_alu_ctrl, id_rd, id_reg_write, id_is_load, flush,
           mem_rd, wb_rd, mem_reg_write, wb_reg_write, mem_is_load, mem_result, wb_result,
           ex_ready,
    output id_ready, ex_valid, ex_op1, ex_op2, ex_alu_ctrl, ex_store_data,
           ex_rd, ex_reg_write, ex_is_load
  );
endinterface

// File: rtl/ex_issue_stage_fwd_sel.sv
// Combinational operand forwarding selector.
//   rs, stored        : source index and the value currently held for it
//   mem_*, wb_*       : producer taps from the MEM and WB stages
//   value             : forwarded operand (x0 always reads as zero)
//   pending           : MEM producer is a load whose data is not yet available
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0]     stored,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic                      mem_reg_write,
  input  logic                      mem_is_load,
  input  logic [DATA_WIDTH-1:0]     mem_result,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      wb_reg_write,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic [DATA_WIDTH-1:0]     value,
  output logic                      pending
);
  fwd_sel_e sel;
  logic     mem_hit;
  logic     wb_hit;

  always_comb begin
    mem_hit = mem_reg_write && (mem_rd == rs) && (rs != '0);
    wb_hit  = wb_reg_write  && (wb_rd  == rs) && (rs != '0);
    pending = mem_hit && mem_is_load;
    // A load in MEM has no data yet, so it falls through to WB/stored.
    sel = FWD_REG;
    if (mem_hit && !mem_is_load) sel = FWD_MEM;
    else if (wb_hit)             sel = FWD_WB;
    case (sel)
      FWD_MEM: value = mem_result;
      FWD_WB:  value = wb_result;
      default: value = stored;
    endcase
    if (rs == '0) value = '0;
  end
endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX issue stage: holds one decoded instruction, forwards MEM/WB results
// into its operands and presents them to the ALU under valid/ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : decode handshake, flush, producer taps, EX handshake/operands
module ex_issue_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CTRL_WIDTH     = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  ex_issue_stage_if.slave  bus
);
  logic                      hold_valid;
  logic [REG_ADDR_WIDTH-1:0] h_rs1, h_rs2, h_rd;
  logic [DATA_WIDTH-1:0]     h_v1, h_v2, h_imm;
  logic                      h_use_imm, h_reg_write, h_is_load;
  logic [CTRL_WIDTH-1:0]     h_ctrl;

  logic [DATA_WIDTH-1:0]     fwd1, fwd2, cap1, cap2;
  logic                      pend1, pend2;
  logic                      unused_cap_pend1, unused_cap_pend2;
  logic                      fire, capture;

  fwd_sel #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs1 (
    .rs(h_rs1), .stored(h_v1),
    .mem_rd(bus.mem_rd), .mem_reg_write(bus.mem_reg_write), .mem_is_load(bus.mem_is_load),
    .mem_result(bus.mem_result), .wb_rd(bus.wb_rd), .wb_reg_write(bus.wb_reg_write),
    .wb_result(bus.wb_result), .value(fwd1), .pending(pend1));

  fwd_sel #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs2 (
    .rs(h_rs2), .stored(h_v2),
    .mem_rd(bus.mem_rd), .mem_reg_write(bus.mem_reg_write), .mem_is_load(bus.mem_is_load),
    .mem_result(bus.mem_result), .wb_rd(bus.wb_rd), .wb_reg_write(bus.wb_reg_write),
    .wb_result(bus.wb_result), .value(fwd2), .pending(pend2));

  // Capture-time forwarding of register-file data; pending is not used here
  // because the hold/refresh path resolves it once the instruction is held.
  fwd_sel #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_cap_rs1 (
    .rs(bus.id_rs1), .stored(bus.id_rs1_data),
    .mem_rd(bus.mem_rd), .mem_reg_write(bus.mem_reg_write), .mem_is_load(bus.mem_is_load),
    .mem_result(bus.mem_result), .wb_rd(bus.wb_rd), .wb_reg_write(bus.wb_reg_write),
    .wb_result(bus.wb_result), .value(cap1), .pending(unused_cap_pend1));

  fwd_sel #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_cap_rs2 (
    .rs(bus.id_rs2), .stored(bus.id_rs2_data),
    .mem_rd(bus.mem_rd), .mem_reg_write(bus.mem_reg_write), .mem_is_load(bus.mem_is_load),
    .mem_result(bus.mem_result), .wb_rd(bus.wb_rd), .wb_reg_write(bus.wb_reg_write),
    .wb_result(bus.wb_result), .value(cap2), .pending(unused_cap_pend2));

  // Any pending rs2 blocks issue, whether it feeds op2 or store data.
  assign bus.ex_valid      = hold_valid && !pend1 && !pend2;
  assign fire              = bus.ex_valid && bus.ex_ready;
  assign bus.id_ready      = !hold_valid || fire;
  assign capture           = bus.id_valid && bus.id_ready && !bus.flush;

  assign bus.ex_op1        = fwd1;
  assign bus.ex_op2        = h_use_imm ? h_imm : fwd2;
  assign bus.ex_store_data = fwd2;
  assign bus.ex_alu_ctrl   = h_ctrl;
  assign bus.ex_rd         = h_rd;
  assign bus.ex_reg_write  = h_reg_write;
  assign bus.ex_is_load    = h_is_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid  <= 1'b0;
      h_rs1       <= '0;
      h_rs2       <= '0;
      h_v1        <= '0;
      h_v2        <= '0;
      h_imm       <= '0;
      h_use_imm   <= 1'b0;
      h_ctrl      <= '0;
      h_rd        <= '0;
      h_reg_write <= 1'b0;
      h_is_load   <= 1'b0;
    end else if (bus.flush) begin
      hold_valid <= 1'b0;
    end else if (capture) begin
      hold_valid  <= 1'b1;
      h_rs1       <= bus.id_rs1;
      h_rs2       <= bus.id_rs2;
      h_v1        <= cap1;
      h_v2        <= cap2;
      h_imm       <= bus.id_imm;
      h_use_imm   <= bus.id_use_imm;
      h_ctrl      <= bus.id_alu_ctrl;
      h_rd        <= bus.id_rd;
      h_reg_write <= bus.id_reg_write;
      h_is_load   <= bus.id_is_load;
    end else if (fire) begin
      hold_valid <= 1'b0;
    end else if (hold_valid) begin
      // Waiting: absorb producers retiring now so their values are not lost.
      h_v1 <= fwd1;
      h_v2 <= fwd2;
    end
  end
endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for the ID/EX issue stage: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a reference model.
module tb_ex_issue_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_issue_stage_if #(.DATA_WIDTH(32), .CTRL_WIDTH(3), .REG_ADDR_WIDTH(5)) bus ();

  ex_issue_stage #(.DATA_WIDTH(32), .CTRL_WIDTH(3), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_data = '0;
    bus.id_rs2_data = '0; bus.id_imm = '0; bus.id_use_imm = 0; bus.id_alu_ctrl = '0;
    bus.id_rd = '0; bus.id_reg_write = 0; bus.id_is_load = 0; bus.flush = 0;
    bus.mem_rd = '0; bus.wb_rd = '0; bus.mem_reg_write = 0; bus.wb_reg_write = 0;
    bus.mem_is_load = 0; bus.mem_result = '0; bus.wb_result = '0; bus.ex_ready = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] imm, input logic use_imm,
                             input logic [2:0] ctrl, input logic [4:0] rd,
                             input logic we, input logic ld);
    bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rs1_data = d1;
    bus.id_rs2_data = d2; bus.id_imm = imm; bus.id_use_imm = use_imm;
    bus.id_alu_ctrl = ctrl; bus.id_rd = rd; bus.id_reg_write = we; bus.id_is_load = ld;
  endtask

  task automatic clear_stage();
    idle_inputs();
    bus.flush = 1;
    next_cycle();
    bus.flush = 0;
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        use_imm;
    logic [2:0]  ctrl;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_we, mem_ld, wb_we;
    logic [31:0] mem_res, wb_res;
    logic        exp_valid;
    logic [31:0] exp_op1, exp_op2, exp_st;
  } vec_t;

  vec_t vecs[8];

  // Reference model state: the one instruction the stage should be holding.
  logic        m_valid;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_v1, m_v2, m_imm;
  logic        m_use_imm, m_we, m_ld;
  logic [2:0]  m_ctrl;

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] stored);
    if (rs == 0) return 32'd0;
    if (bus.mem_reg_write && bus.mem_rd == rs && !bus.mem_is_load) return bus.mem_result;
    if (bus.wb_reg_write && bus.wb_rd == rs) return bus.wb_result;
    return stored;
  endfunction

  function automatic logic ref_pend(input logic [4:0] rs);
    return rs != 0 && bus.mem_reg_write && bus.mem_rd == rs && bus.mem_is_load;
  endfunction

  initial begin
    logic        e_valid, e_fire, e_idr;
    logic [31:0] e_op1, e_op2;

    vecs[0] = '{5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 3'd0,
                5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd5, 32'd7, 32'd7};
    vecs[1] = '{5'd4, 5'd0, 5'd8, 32'd1, 32'd0, 32'd0, 1'b0, 3'd1,
                5'd4, 5'd4, 1'b1, 1'b0, 1'b1, 32'h10, 32'h20, 1'b1, 32'h10, 32'd0, 32'd0};
    vecs[2] = '{5'd6, 5'd2, 5'd9, 32'd3, 32'd8, 32'd0, 1'b0, 3'd2,
                5'd6, 5'd0, 1'b1, 1'b1, 1'b0, 32'h99, 32'd0, 1'b0, 32'd3, 32'd8, 32'd8};
    vecs[3] = '{5'd0, 5'd1, 5'd2, 32'h77, 32'd2, 32'd0, 1'b0, 3'd3,
                5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h55, 32'd0, 1'b1, 32'd0, 32'd2, 32'd2};
    vecs[4] = '{5'd1, 5'd2, 5'd7, 32'd4, 32'd9, 32'h100, 1'b1, 3'd5,
                5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 32'd0, 32'hC, 1'b1, 32'd4, 32'h100, 32'hC};
    vecs[5] = '{5'd1, 5'd2, 5'd7, 32'd4, 32'd9, 32'h44, 1'b1, 3'd0,
                5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 32'h1, 32'd0, 1'b0, 32'd4, 32'h44, 32'd9};
    vecs[6] = '{5'd5, 5'd5, 5'd1, 32'd1, 32'd1, 32'd0, 1'b0, 3'd1,
                5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 32'd0, 32'h33, 1'b1, 32'h33, 32'h33, 32'h33};
    vecs[7] = '{5'd3, 5'd4, 5'd6, 32'd11, 32'd12, 32'd0, 1'b0, 3'd2,
                5'd7, 5'd3, 1'b1, 1'b0, 1'b1, 32'hEE, 32'h3C, 1'b1, 32'h3C, 32'd12, 32'd12};

    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("reset_id_ready", {31'd0, bus.id_ready}, 32'd1);
    chk("reset_op1", bus.ex_op1, 32'd0);
    chk("reset_op2", bus.ex_op2, 32'd0);
    chk("reset_rd", {27'd0, bus.ex_rd}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Directed vectors: capture with idle producers, then present producers.
    foreach (vecs[i]) begin
      clear_stage();
      drive_instr(vecs[i].rs1, vecs[i].rs2, vecs[i].d1, vecs[i].d2, vecs[i].imm,
                  vecs[i].use_imm, vecs[i].ctrl, vecs[i].rd, 1'b1, 1'b0);
      next_cycle();
      idle_inputs();
      bus.mem_rd = vecs[i].mem_rd; bus.mem_reg_write = vecs[i].mem_we;
      bus.mem_is_load = vecs[i].mem_ld; bus.mem_result = vecs[i].mem_res;
      bus.wb_rd = vecs[i].wb_rd; bus.wb_reg_write = vecs[i].wb_we;
      bus.wb_result = vecs[i].wb_res;
      #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.ex_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_op1", i), bus.ex_op1, vecs[i].exp_op1);
      chk($sformatf("vec%0d_op2", i), bus.ex_op2, vecs[i].exp_op2);
      chk($sformatf("vec%0d_store", i), bus.ex_store_data, vecs[i].exp_st);
      chk($sformatf("vec%0d_rd_ctrl", i), {24'd0, bus.ex_rd, bus.ex_alu_ctrl},
          {24'd0, vecs[i].rd, vecs[i].ctrl});
    end

    // Load-use: one stalled cycle, then WB supplies the loaded value.
    clear_stage();
    drive_instr(5'd6, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd7, 1'b1, 1'b0);
    next_cycle();
    idle_inputs();
    bus.ex_ready = 1;
    bus.mem_rd = 5'd6; bus.mem_reg_write = 1; bus.mem_is_load = 1; bus.mem_result = 32'hDEAD;
    #1;
    chk("loaduse_stall_valid", {31'd0, bus.ex_valid}, 32'd0);
    next_cycle();
    idle_inputs();
    bus.ex_ready = 1;
    bus.wb_rd = 5'd6; bus.wb_reg_write = 1; bus.wb_result = 32'hAB;
    #1;
    chk("loaduse_release_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("loaduse_op1", bus.ex_op1, 32'hAB);

    // Downstream stall while WB retires rs2; the refresh must keep the value.
    clear_stage();
    drive_instr(5'd1, 5'd5, 32'd2, 32'd1, 32'd0, 1'b0, 3'd0, 5'd3, 1'b0, 1'b0);
    next_cycle();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      bus.id_valid = 1;
      bus.wb_reg_write = (c == 0); bus.wb_rd = 5'd5; bus.wb_result = 32'd9;
      #1;
      chk($sformatf("stall%0d_id_ready", c), {31'd0, bus.id_ready}, 32'd0);
      next_cycle();
    end
    idle_inputs();
    bus.ex_ready = 1;
    #1;
    chk("stall_store_data", bus.ex_store_data, 32'd9);
    chk("stall_release_id_ready", {31'd0, bus.id_ready}, 32'd1);

    // Flush beats both a pending capture and the held instruction.
    clear_stage();
    drive_instr(5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, 3'd0, 5'd3, 1'b1, 1'b0);
    next_cycle();
    drive_instr(5'd2, 5'd3, 32'd4, 32'd5, 32'd0, 1'b0, 3'd1, 5'd9, 1'b1, 1'b0);
    bus.ex_ready = 1;
    bus.flush = 1;
    next_cycle();
    idle_inputs();
    #1;
    chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("flush_id_ready", {31'd0, bus.id_ready}, 32'd1);

    // Asynchronous reset mid-operation.
    drive_instr(5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, 3'd0, 5'd3, 1'b1, 1'b0);
    next_cycle();
    idle_inputs();
    #1;
    chk("prereset_valid", {31'd0, bus.ex_valid}, 32'd1);
    rst_n = 0;
    #1;
    chk("async_reset_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("async_reset_op1", bus.ex_op1, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Randomized traffic against the reference model.
    clear_stage();
    m_valid = 0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_v1 = '0; m_v2 = '0; m_imm = '0;
    m_use_imm = 0; m_we = 0; m_ld = 0; m_ctrl = '0;
    for (int n = 0; n < 400; n++) begin
      drive_instr(5'($urandom_range(3)), 5'($urandom_range(3)), $urandom, $urandom, $urandom,
                  1'($urandom), 3'($urandom), 5'($urandom_range(31)), 1'($urandom), 1'($urandom));
      bus.id_valid = ($urandom_range(3) != 0);
      bus.flush = ($urandom_range(15) == 0);
      bus.ex_ready = ($urandom_range(9) < 7);
      bus.mem_rd = 5'($urandom_range(3)); bus.mem_reg_write = 1'($urandom);
      bus.mem_is_load = 1'($urandom); bus.mem_result = $urandom;
      bus.wb_rd = 5'($urandom_range(3)); bus.wb_reg_write = 1'($urandom);
      bus.wb_result = $urandom;
      #1;
      e_valid = m_valid && !ref_pend(m_rs1) && !ref_pend(m_rs2);
      e_idr = !m_valid || (e_valid && bus.ex_ready);
      chk($sformatf("rnd%0d_valid", n), {31'd0, bus.ex_valid}, {31'd0, e_valid});
      chk($sformatf("rnd%0d_id_ready", n), {31'd0, bus.id_ready}, {31'd0, e_idr});
      if (m_valid) begin
        e_op1 = ref_fwd(m_rs1, m_v1);
        e_op2 = m_use_imm ? m_imm : ref_fwd(m_rs2, m_v2);
        chk($sformatf("rnd%0d_op1", n), bus.ex_op1, e_op1);
        chk($sformatf("rnd%0d_op2", n), bus.ex_op2, e_op2);
        chk($sformatf("rnd%0d_store", n), bus.ex_store_data, ref_fwd(m_rs2, m_v2));
        chk($sformatf("rnd%0d_ctl", n), {23'd0, bus.ex_rd, bus.ex_alu_ctrl, bus.ex_reg_write, bus.ex_is_load},
            {23'd0, m_rd, m_ctrl, m_we, m_ld});
      end
      e_fire = e_valid && bus.ex_ready;
      if (bus.flush) m_valid = 0;
      else if (bus.id_valid && e_idr) begin
        m_valid = 1;
        m_rs1 = bus.id_rs1; m_rs2 = bus.id_rs2;
        m_v1 = ref_fwd(bus.id_rs1, bus.id_rs1_data);
        m_v2 = ref_fwd(bus.id_rs2, bus.id_rs2_data);
        m_imm = bus.id_imm; m_use_imm = bus.id_use_imm; m_ctrl = bus.id_alu_ctrl;
        m_rd = bus.id_rd; m_we = bus.id_reg_write; m_ld = bus.id_is_load;
      end else if (e_fire) m_valid = 0;
      else if (m_valid) begin
        m_v1 = ref_fwd(m_rs1, m_v1);
        m_v2 = ref_fwd(m_rs2, m_v2);
      end
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_issue_stage.md
# ex_issue_stage

ID/EX pipeline stage that feeds the ALU. It captures a decoded instruction from the decode stage and resolves operand hazards by forwarding results from the MEM and WB stages. It presents `op1`/`op2`/`ctrl` to the ALU under a valid/ready handshake. Operands waiting on an in-flight load are held back until the load data reaches WB.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `CTRL_WIDTH`, 3, ALU control width
- `REG_ADDR_WIDTH`, 5, register index width
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  decode stage has an instruction
- `id_ready`  out  1  stage can accept this cycle
- `id_rs1`, `id_rs2`  in  REG_ADDR_WIDTH  source register indices
- `id_rs1_data`, `id_rs2_data`  in  DATA_WIDTH  register-file read data
- `id_imm`  in  DATA_WIDTH  sign-extended immediate
- `id_use_imm`  in  1  op2 takes the immediate
- `id_alu_ctrl`  in  CTRL_WIDTH  ALU mode
- `id_rd`  in  REG_ADDR_WIDTH  destination index
- `id_reg_write`, `id_is_load`  in  1  writeback enable; load flag
- `flush`  in  1  discard the held instruction (taken branch)
- `mem_rd`, `wb_rd`  in  REG_ADDR_WIDTH  producer destinations
- `mem_reg_write`, `wb_reg_write`  in  1  producer writes a register
- `mem_is_load`  in  1  MEM producer is a load (value not yet available)
- `mem_result`, `wb_result`  in  DATA_WIDTH  producer values
- `ex_valid`  out  1  ALU inputs valid
- `ex_ready`  in  1  downstream accepts
- `ex_op1`, `ex_op2`  out  DATA_WIDTH  ALU operands
- `ex_alu_ctrl`  out  CTRL_WIDTH  ALU mode
- `ex_store_data`  out  DATA_WIDTH  forwarded rs2 value
- `ex_rd`, `ex_reg_write`, `ex_is_load`  out  pass-through control

## Operation
- Held state: `hold_valid`, rs1/rs2 indices, stored rs1/rs2 values, imm, use_imm, ctrl, rd, reg_write, is_load.
- Forward rule for each operand, in priority order:
  - MEM match (`mem_reg_write`, `mem_rd == rs`, `rs != 0`) takes `mem_result`, unless `mem_is_load`.
  - Otherwise a WB match takes `wb_result`.
  - Otherwise the stored value is used.
  - `rs == 0` always yields 0.
- Pending: an operand is pending when its MEM match has `mem_is_load` = 1.
- `ex_valid = hold_valid && !pending(rs1) && !(pending(rs2) && (!use_imm || is_load == 0 && reg_write == 0))`.
  - Simplified rule: rs2 pending blocks whenever rs2 is consumed as op2 or as store data. The implementation treats any rs2 pending as blocking.
- `ex_op1` = forwarded rs1. `ex_op2` = `use_imm ? imm : forwarded rs2`. `ex_store_data` = forwarded rs2.
- Capture-time forwarding: on capture, stored rs values take the forwarded form of `id_rsN_data` under the same MEM/WB rule, with no pending logic.
- Refresh: every cycle the stage holds without firing, stored rs values are overwritten with their forwarded values. This covers producers that retire while the instruction waits.
- `fire = ex_valid && ex_ready`.
- `id_ready = !hold_valid || fire`.
- Capture occurs when `id_valid && id_ready`.
- Flush: next state has `hold_valid = 0` and no capture that cycle, regardless of `id_valid`. Flush wins over capture and fire.

## Timing
- Reset values: `hold_valid`, all stored fields and all outputs are 0, so `ex_valid` = 0 and `id_ready` = 1.
- ID to EX latency is 1 cycle. Back-to-back throughput is one instruction per cycle while `ex_ready` = 1.
- Combinational paths: `ex_op*`, `ex_store_data` and `ex_valid` depend on the held registers and the current mem/wb inputs.
- `id_ready` depends combinationally on `ex_ready`.
- Load-use: the dependent instruction sits in EX with `ex_valid` = 0 for exactly one cycle, then the WB forward supplies the value.
- `ex_ready` low: all held fields are stable except stored values refreshed by forwarding.
- Reset mid-operation: `rst_n` asserted clears state immediately, asynchronously.

## Structure
- Package `cpu_pkg`:
  - `alu_ctrl_e` {ADD=0, SUB=1, AND=2, OR=3, SLT=5}, shared with the ALU.
  - `fwd_sel_e` {FWD_REG, FWD_MEM, FWD_WB}.
- Sub-module `fwd_sel` (combinational):
  - Inputs: rs, stored value, mem/wb producer signals.
  - Outputs: forwarded value, pending.
  - Instantiated for rs1 and rs2, and twice more for capture-time forwarding.

## Test plan
- Reset, then capture add x3 ← x1(5) + x2(7), ctrl=0 -> next cycle `ex_valid`=1, `ex_op1`=5, `ex_op2`=7, `ex_rd`=3.
- EX holds rs1=x4 (stored 1); MEM has rd=4, result 0x10, `mem_reg_write`=1 while WB has rd=4, result 0x20 -> `ex_op1`=0x10 (MEM priority).
- EX holds rs1=x6; MEM has rd=6 with `mem_is_load`=1 -> `ex_valid`=0. Next cycle WB has rd=6, result 0xAB -> `ex_valid`=1, `ex_op1`=0xAB.
- `ex_ready`=0 for 3 cycles while WB retires rd=rs2 with value 9 in cycle 1 -> `id_ready`=0 throughout; after release, `ex_store_data`=9.
- `flush`=1 with `id_valid`=1 and `hold_valid`=1 -> next cycle `ex_valid`=0, nothing captured.
- MEM producer with rd=0, result 0x55, matches rs1=0 -> `ex_op1`=0.
